// File: rtl/seg_scan_sched.sv
// seg_scan_sched: page scheduler and digit multiplexer for a 4-digit
// seven-segment display on the 190 Hz scan clock.
// Page A and page B share the display. Manual mode shows the page picked by
// sel. Auto mode rotates between the pages every DWELL frames.
// The digits of the chosen page are captured once per frame at the frame
// boundary, so a frame never mixes old and new input values.
// Optional feature: define SEG_LZ_BLANK_EN to blank leading zeros
// (digits 3..1) of the captured frame.
module seg_scan_sched #(
  parameter int DWELL = 190
) (
  input  logic        clk190hz,
  input  logic        rst,
  input  logic        sel,
  input  logic        auto,
  input  logic [15:0] a_digits,
  input  logic        a_valid,
  input  logic [15:0] b_digits,
  input  logic        b_valid,
  output logic [3:0]  pos,
  output logic [7:0]  seg,
  output logic        page
);

  localparam int DW_W = $clog2(DWELL + 1);

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    SHOW_A = 2'd1,
    SHOW_B = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [1:0]      idx_q;
  logic [15:0]     fbuf_q, fbuf_d;
  logic [3:0]      pos_q, pos_d;
  logic [7:0]      seg_q, seg_d;
  logic            page_q;
  logic [3:0]      nib_s;
  logic [3:0]      lz_s;
  logic            dwell_last_s;

  // BCD nibble to gfedcba pattern; codes 10..15 show a dash as an error mark.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

  assign dwell_last_s = (dwell_q == DW_W'(DWELL - 1));

  // Page selection for the next frame; only committed at the frame boundary.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    if (!auto) begin
      dwell_d = '0;
      if (sel) begin
        state_d = b_valid ? SHOW_B : BLANK;
      end else begin
        state_d = a_valid ? SHOW_A : BLANK;
      end
    end else begin
      case (state_q)
        BLANK: begin
          dwell_d = '0;
          if (a_valid) begin
            state_d = SHOW_A;
          end else if (b_valid) begin
            state_d = SHOW_B;
          end else begin
            state_d = BLANK;
          end
        end
        SHOW_A: begin
          if (!a_valid) begin
            dwell_d = '0;
            state_d = b_valid ? SHOW_B : BLANK;
          end else if (dwell_last_s) begin
            dwell_d = '0;
            state_d = b_valid ? SHOW_B : SHOW_A;
          end else begin
            dwell_d = dwell_q + DW_W'(1);
            state_d = SHOW_A;
          end
        end
        SHOW_B: begin
          if (!b_valid) begin
            dwell_d = '0;
            state_d = a_valid ? SHOW_A : BLANK;
          end else if (dwell_last_s) begin
            dwell_d = '0;
            state_d = a_valid ? SHOW_A : SHOW_B;
          end else begin
            dwell_d = dwell_q + DW_W'(1);
            state_d = SHOW_B;
          end
        end
        default: begin
          dwell_d = '0;
          state_d = BLANK;
        end
      endcase
    end
  end

  // Digits captured for the next frame follow the page that frame will show.
  always_comb begin
    case (state_d)
      SHOW_A:  fbuf_d = a_digits;
      SHOW_B:  fbuf_d = b_digits;
      default: fbuf_d = 16'h0000;
    endcase
  end

  // Pick the nibble of the digit being scanned from the captured frame.
  always_comb begin
    case (idx_q)
      2'd0:    nib_s = fbuf_q[3:0];
      2'd1:    nib_s = fbuf_q[7:4];
      2'd2:    nib_s = fbuf_q[11:8];
      2'd3:    nib_s = fbuf_q[15:12];
      default: nib_s = 4'h0;
    endcase
  end

  // Leading-zero mask: a digit is blanked when it and every higher digit are 0.
  always_comb begin
`ifdef SEG_LZ_BLANK_EN
    lz_s[3] = (fbuf_q[15:12] == 4'h0);
    lz_s[2] = (fbuf_q[15:8] == 8'h00);
    lz_s[1] = (fbuf_q[15:4] == 12'h000);
    lz_s[0] = 1'b0;
`else
    lz_s = 4'b0000;
`endif
  end

  // Next digit enable and segment pattern; dp marks digit3 of a page-B frame.
  always_comb begin
    pos_d = 4'b0001 << idx_q;
    if ((state_q == BLANK) || lz_s[idx_q]) begin
      seg_d[6:0] = 7'h00;
    end else begin
      seg_d[6:0] = seg7_decode(nib_s);
    end
    seg_d[7] = (idx_q == 2'd3) && (state_q == SHOW_B);
  end

  // Scan counter, registered outputs, and boundary-only page/frame updates.
  always_ff @(posedge clk190hz) begin
    if (!rst) begin
      idx_q   <= 2'd0;
      pos_q   <= 4'b0000;
      seg_q   <= 8'h00;
      page_q  <= 1'b0;
      state_q <= BLANK;
      dwell_q <= '0;
      fbuf_q  <= 16'h0000;
    end else begin
      idx_q <= idx_q + 2'd1;
      pos_q <= pos_d;
      seg_q <= seg_d;
      if (idx_q == 2'd3) begin
        state_q <= state_d;
        dwell_q <= dwell_d;
        fbuf_q  <= fbuf_d;
        page_q  <= (state_d == SHOW_B);
      end else begin
        state_q <= state_q;
        dwell_q <= dwell_q;
        fbuf_q  <= fbuf_q;
        page_q  <= page_q;
      end
    end
  end

  assign pos  = pos_q;
  assign seg  = seg_q;
  assign page = page_q;

endmodule

// File: tb/tb_seg_scan_sched.sv
// Directed bench for seg_scan_sched with a scoreboard queue: the stimulus
// process pushes the expected pos/seg/page for each clock edge, and a monitor
// pops and compares one entry just after every rising edge.
module tb_seg_scan_sched;

  logic        clk190hz;
  logic        rst;
  logic        sel;
  logic        auto;
  logic [15:0] a_digits;
  logic        a_valid;
  logic [15:0] b_digits;
  logic        b_valid;
  logic [3:0]  pos;
  logic [7:0]  seg;
  logic        page;

  seg_scan_sched #(.DWELL(2)) dut (
    .clk190hz (clk190hz),
    .rst      (rst),
    .sel      (sel),
    .auto     (auto),
    .a_digits (a_digits),
    .a_valid  (a_valid),
    .b_digits (b_digits),
    .b_valid  (b_valid),
    .pos      (pos),
    .seg      (seg),
    .page     (page)
  );

`ifdef SEG_LZ_BLANK_EN
  localparam logic [7:0] LZ0 = 8'h00;
`else
  localparam logic [7:0] LZ0 = 8'h3F;
`endif
  localparam logic [7:0] B3 = LZ0 | 8'h80;

  typedef struct {
    string      tag;
    logic [3:0] pos;
    logic [7:0] seg;
    logic       pg;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;

  initial clk190hz = 1'b0;
  always #5 clk190hz = ~clk190hz;

  // Monitor: one expectation per rising edge, compared 1 ns after the edge.
  always @(posedge clk190hz) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_vec++;
      if ((pos !== mon_e.pos) || (seg !== mon_e.seg) || (page !== mon_e.pg)) begin
        n_miss++;
        $display("FAIL %s: got pos=%b seg=%h page=%b, want pos=%b seg=%h page=%b",
                 mon_e.tag, pos, seg, page, mon_e.pos, mon_e.seg, mon_e.pg);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input string tag, input logic [3:0] p, input logic [7:0] s,
                      input logic pg);
    exp_t e;
    e.tag = tag;
    e.pos = p;
    e.seg = s;
    e.pg  = pg;
    sb.push_back(e);
    @(negedge clk190hz);
  endtask

  // One full frame: digits 0..3, page pc during the frame, pn after boundary.
  task automatic exp_frame(input string tag, input logic [7:0] s0, s1, s2, s3,
                           input logic pc, input logic pn);
    step(tag, 4'b0001, s0, pc);
    step(tag, 4'b0010, s1, pc);
    step(tag, 4'b0100, s2, pc);
    step(tag, 4'b1000, s3, pn);
  endtask

  initial begin
    rst      = 1'b0;
    sel      = 1'b0;
    auto     = 1'b0;
    a_digits = 16'h1234;
    a_valid  = 1'b1;
    b_digits = 16'h0987;
    b_valid  = 1'b0;

    step("reset0", 4'b0000, 8'h00, 1'b0);
    step("reset1", 4'b0000, 8'h00, 1'b0);
    rst = 1'b1;

    // Manual mode, page A.
    exp_frame("blank_after_rst", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    step("a_d0", 4'b0001, 8'h66, 1'b0);
    sel     = 1'b1;
    b_valid = 1'b1;
    step("a_d1_no_tear", 4'b0010, 8'h4F, 1'b0);
    step("a_d2_no_tear", 4'b0100, 8'h5B, 1'b0);
    step("a_d3_to_b", 4'b1000, 8'h06, 1'b1);
    exp_frame("manual_b", 8'h07, 8'h7F, 8'h6F, B3, 1'b1, 1'b1);

    // Auto mode: drop to BLANK, then rotate with DWELL = 2.
    auto    = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    exp_frame("auto_b_to_blank", 8'h07, 8'h7F, 8'h6F, B3, 1'b1, 1'b0);
    exp_frame("auto_blank", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    a_valid = 1'b1;
    b_valid = 1'b1;
    exp_frame("auto_blank_to_a", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    exp_frame("auto_a1", 8'h66, 8'h4F, 8'h5B, 8'h06, 1'b0, 1'b0);
    exp_frame("auto_a2", 8'h66, 8'h4F, 8'h5B, 8'h06, 1'b0, 1'b1);
    exp_frame("auto_b1", 8'h07, 8'h7F, 8'h6F, B3, 1'b1, 1'b1);
    exp_frame("auto_b2", 8'h07, 8'h7F, 8'h6F, B3, 1'b1, 1'b0);
    exp_frame("auto_a3", 8'h66, 8'h4F, 8'h5B, 8'h06, 1'b0, 1'b0);
    exp_frame("auto_a4", 8'h66, 8'h4F, 8'h5B, 8'h06, 1'b0, 1'b1);
    b_valid = 1'b0;
    exp_frame("auto_b_drop", 8'h07, 8'h7F, 8'h6F, B3, 1'b1, 1'b0);
    exp_frame("auto_dwell_restart", 8'h66, 8'h4F, 8'h5B, 8'h06, 1'b0, 1'b0);
    exp_frame("auto_stay_a", 8'h66, 8'h4F, 8'h5B, 8'h06, 1'b0, 1'b0);

    // Manual A with a non-BCD nibble, then a leading-zero value.
    auto     = 1'b0;
    sel      = 1'b0;
    a_digits = 16'h00A5;
    exp_frame("man_a_old", 8'h66, 8'h4F, 8'h5B, 8'h06, 1'b0, 1'b0);
    a_digits = 16'h0005;
    exp_frame("dash", 8'h6D, 8'h40, LZ0, LZ0, 1'b0, 1'b0);
    exp_frame("lead_zero", 8'h6D, LZ0, LZ0, LZ0, 1'b0, 1'b0);

    // Reset asserted on idx = 2, mid-frame.
    step("pre_rst_d0", 4'b0001, 8'h6D, 1'b0);
    step("pre_rst_d1", 4'b0010, LZ0, 1'b0);
    rst = 1'b0;
    step("mid_rst", 4'b0000, 8'h00, 1'b0);
    step("mid_rst_hold", 4'b0000, 8'h00, 1'b0);
    rst = 1'b1;
    exp_frame("blank_after_mid_rst", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    exp_frame("a_after_mid_rst", 8'h6D, LZ0, LZ0, LZ0, 1'b0, 1'b0);

    @(posedge clk190hz);
    #2;
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
